// File: rtl/symbol_byte_packer_pkg.sv
// Shared definitions for the symbol byte packer: FSM encoding, tuser modulation
// encodings and the word/pad width derivations.
package symbol_byte_packer_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    localparam logic MODE_BPSK = 1'b1;
    localparam logic MODE_QPSK = 1'b0;

    function automatic int calc_bits(input int bytes);
        return bytes * 8;
    endfunction

    function automatic int calc_pad_w(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/symbol_byte_packer_axis_hold_reg.sv
// Single-entry AXIS register slice carrying a packed word, its last flag and its
// zero-pad count; the parent only loads it when it is empty or draining.
module axis_hold_reg #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    input  logic [PW-1:0] pad_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    output logic [PW-1:0] pad_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          last_q;
    logic [PW-1:0] pad_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            pad_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
            pad_q   <= pad_i;
        end else if (ready_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign pad_o   = pad_q;

endmodule

// File: rtl/symbol_byte_packer.sv
// Packs a BPSK/QPSK symbol stream MSB-first into BYTES-wide AXIS words with
// zero-pad reporting; upstream never stalls, so dropped symbols raise overflow.
module symbol_byte_packer
    import symbol_byte_packer_pkg::*;
#(
    parameter int BYTES = 1,
    parameter int CNT_W = 16,
    localparam int BITS  = calc_bits(BYTES),
    localparam int PAD_W = calc_pad_w(BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    input  logic             s_tuser,
    output logic             s_tready,
    output logic [BITS-1:0]  m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [PAD_W-1:0] m_tpad,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam logic [PAD_W-1:0] CNT_FULL = PAD_W'(BITS);
    localparam logic [BITS-1:0]  MSB_BIT  = {1'b1, {(BITS-1){1'b0}}};

    state_e             state_q, state_d;
    logic [BITS-1:0]    acc_q, acc_d;
    logic [PAD_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;

    logic               hold_load;
    logic [BITS-1:0]    hold_data;
    logic               hold_last;
    logic [PAD_W-1:0]   hold_pad;

    logic               is_qpsk;
    logic               load_ok;
    logic               acc_full;
    logic               drain;
    logic               split;
    logic               need_slot;
    logic               accept;
    logic [BITS-1:0]    base_acc;
    logic [PAD_W-1:0]   base_cnt;
    logic [BITS-1:0]    word;
    logic [PAD_W-1:0]   new_cnt;

    assign is_qpsk  = (s_tuser == MODE_QPSK);
    assign load_ok  = !m_tvalid || m_tready;
    assign acc_full = (cnt_q == CNT_FULL);

    // A completed non-final word may park in acc (cnt == BITS) while hold is
    // blocked; only symbols that need a fresh hold slot are refused then.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hold_load = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        hold_pad  = '0;
        s_tready  = 1'b0;
        drain     = 1'b0;
        split     = 1'b0;
        need_slot = 1'b0;
        accept    = 1'b0;
        base_acc  = acc_q;
        base_cnt  = cnt_q;
        word      = acc_q;
        new_cnt   = cnt_q;

        case (state_q)
            ST_ACC: begin
                drain = acc_full && load_ok;
                if (drain) begin
                    base_acc  = '0;
                    base_cnt  = '0;
                    hold_load = 1'b1;
                    hold_data = acc_q;
                end

                split = is_qpsk && (base_cnt == CNT_FULL - PAD_W'(1));
                word  = base_acc;
                if (s_tdata[1]) begin
                    word = word | (MSB_BIT >> base_cnt);
                end
                if (is_qpsk && !split && s_tdata[0]) begin
                    word = word | (MSB_BIT >> (base_cnt + PAD_W'(1)));
                end
                new_cnt = base_cnt + (is_qpsk ? PAD_W'(2) : PAD_W'(1));

                need_slot = acc_full || s_tlast || split;
                s_tready  = !(!load_ok && need_slot);
                accept    = s_tvalid && s_tready;

                if (accept) begin
                    if (split) begin
                        hold_load = 1'b1;
                        hold_data = word;
                        acc_d     = s_tdata[0] ? MSB_BIT : '0;
                        cnt_d     = PAD_W'(1);
                        if (s_tlast) begin
                            state_d = ST_FLUSH;
                        end
                    end else if (new_cnt == CNT_FULL) begin
                        if (load_ok) begin
                            hold_load = 1'b1;
                            hold_data = word;
                            hold_last = s_tlast;
                            acc_d     = '0;
                            cnt_d     = '0;
                        end else begin
                            acc_d = word;
                            cnt_d = new_cnt;
                        end
                    end else if (s_tlast) begin
                        if (!drain) begin
                            hold_load = 1'b1;
                            hold_data = word;
                            hold_last = 1'b1;
                            hold_pad  = CNT_FULL - new_cnt;
                            acc_d     = '0;
                            cnt_d     = '0;
                        end else begin
                            acc_d   = word;
                            cnt_d   = new_cnt;
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        acc_d = word;
                        cnt_d = new_cnt;
                    end
                end else if (drain) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end

            ST_FLUSH: begin
                if (load_ok) begin
                    hold_load = 1'b1;
                    hold_data = acc_q;
                    hold_last = 1'b1;
                    hold_pad  = CNT_FULL - cnt_q;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_ACC;
                end
            end

            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (s_tvalid && !s_tready) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        pkt_d = pkt_q;
        if (m_tvalid && m_tready && m_tlast) begin
            pkt_d = pkt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pkt_q   <= pkt_d;
        end
    end

    axis_hold_reg #(
        .DW (BITS),
        .PW (PAD_W)
    ) u_hold (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (hold_load),
        .data_i  (hold_data),
        .last_i  (hold_last),
        .pad_i   (hold_pad),
        .ready_i (m_tready),
        .valid_o (m_tvalid),
        .data_o  (m_tdata),
        .last_o  (m_tlast),
        .pad_o   (m_tpad)
    );

    assign overflow = ovf_q;
    assign pkt_cnt  = pkt_q;

endmodule
